// File: rtl/flash_boot_loader_if.sv
// Bundle of the loader's SPI flash pins, RAM write port and start/status
// handshake. The loader drives through the master modport. The flash,
// the RAM and the top-level glue sit on the slave side.
interface flash_boot_loader_if;
    logic        start;
    logic        flash_sck;
    logic        flash_mosi;
    logic        flash_miso;
    logic        flash_cs_n;
    logic        mem_write_enable;
    logic [0:15] mem_write_addr;
    logic [0:15] mem_write_data;
    logic        busy;
    logic        done;

    modport master (
        input  start,
        input  flash_miso,
        output flash_sck,
        output flash_mosi,
        output flash_cs_n,
        output mem_write_enable,
        output mem_write_addr,
        output mem_write_data,
        output busy,
        output done
    );

    modport slave (
        output start,
        output flash_miso,
        input  flash_sck,
        input  flash_mosi,
        input  flash_cs_n,
        input  mem_write_enable,
        input  mem_write_addr,
        input  mem_write_data,
        input  busy,
        input  done
    );
endinterface

// File: rtl/flash_boot_loader.sv
// Boot-time copier: wakes the SPI flash from deep power-down, then streams
// WORDS big-endian 16-bit words from FLASH_OFFSET into RAM addresses
// 0..WORDS-1. It holds busy while it owns the RAM write port and raises a
// sticky done at the end.
module flash_boot_loader #(
    parameter logic [23:0] FLASH_OFFSET = 24'h020000,
    parameter int unsigned WORDS        = 4096,
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned WAKE_WAIT    = 160
) (
    input logic                 clk,
    input logic                 resetq,
    flash_boot_loader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAKE_CMD,
        WAKE_GAP,
        READ_CMD,
        READ_DATA,
        DONE
    } state_t;

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST   = 16'(WAKE_WAIT - 1);
    localparam logic [15:0] WORD_END   = 16'(WORDS);
    localparam logic [31:0] WAKE_FRAME = {8'hAB, 24'h000000};
    localparam logic [31:0] READ_FRAME = {8'h03, FLASH_OFFSET};

    state_t      state_q;
    logic [15:0] div_q;
    logic [15:0] gap_q;
    logic [15:0] word_q;
    logic [4:0]  bit_q;
    logic [31:0] tx_q;
    logic [0:15] rx_q;
    logic        sck_q;
    logic        cs_n_q;
    logic        we_q;
    logic        busy_q;
    logic        done_q;
    logic [0:15] addr_q;
    logic [0:15] data_q;

    logic shifting;
    logic tick;
    logic rise;
    logic fall;

    // SCK phase timing: each half-period lasts CLK_DIV cycles while a transfer is active
    always_comb begin
        shifting = (state_q == WAKE_CMD) || (state_q == READ_CMD) || (state_q == READ_DATA);
        tick     = shifting && (div_q == DIV_LAST);
        rise     = tick && !sck_q;
        fall     = tick && sck_q;
    end

    // Sequencer: SPI shifting, wake gap, word assembly and RAM write strobes
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= IDLE;
            div_q   <= '0;
            gap_q   <= '0;
            word_q  <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            we_q <= 1'b0;

            if (shifting) begin
                if (tick) begin
                    div_q <= '0;
                    sck_q <= ~sck_q;
                end else begin
                    div_q <= div_q + 16'd1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= WAKE_CMD;
                        busy_q  <= 1'b1;
                        cs_n_q  <= 1'b0;
                        tx_q    <= WAKE_FRAME;
                        div_q   <= '0;
                        bit_q   <= '0;
                        sck_q   <= 1'b0;
                        word_q  <= '0;
                    end
                end

                WAKE_CMD: begin
                    // MOSI is tx_q[31]; shifting only on the falling half keeps it stable while SCK is high
                    if (fall) begin
                        tx_q  <= {tx_q[30:0], 1'b0};
                        bit_q <= bit_q + 5'd1;
                        if (bit_q == 5'd7) begin
                            cs_n_q  <= 1'b1;
                            gap_q   <= '0;
                            state_q <= WAKE_GAP;
                        end
                    end
                end

                WAKE_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= READ_CMD;
                        cs_n_q  <= 1'b0;
                        tx_q    <= READ_FRAME;
                        div_q   <= '0;
                        bit_q   <= '0;
                        sck_q   <= 1'b0;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end

                READ_CMD: begin
                    // Once 32 shifts are done tx_q is empty, so MOSI reads 0 during the data phase
                    if (fall) begin
                        tx_q <= {tx_q[30:0], 1'b0};
                        if (bit_q == 5'd31) begin
                            bit_q   <= '0;
                            state_q <= READ_DATA;
                        end else begin
                            bit_q <= bit_q + 5'd1;
                        end
                    end
                end

                READ_DATA: begin
                    if (rise) begin
                        rx_q <= {rx_q[1:15], bus.flash_miso};
                        if (bit_q == 5'd15) begin
                            bit_q  <= '0;
                            we_q   <= 1'b1;
                            addr_q <= word_q;
                            data_q <= {rx_q[1:15], bus.flash_miso};
                            word_q <= word_q + 16'd1;
                        end else begin
                            bit_q <= bit_q + 5'd1;
                        end
                    end
                    // The SCK toggle above already drives SCK low on this half-period boundary
                    if (fall && (word_q == WORD_END)) begin
                        cs_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    state_q <= DONE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.flash_sck        = sck_q;
    assign bus.flash_mosi       = tx_q[31];
    assign bus.flash_cs_n       = cs_n_q;
    assign bus.mem_write_enable = we_q;
    assign bus.mem_write_addr   = addr_q;
    assign bus.mem_write_data   = data_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;

endmodule
